// File: rtl/macc_sched_pkg.sv
// Shared defaults, latency constant and response record for the multiply-add scheduler.
// Also holds the modulo-increment helper used by the round-robin pointer and FIFO pointers.
package macc_sched_pkg;

    localparam int unsigned N_REQ_DEF      = 4;
    localparam int unsigned A_W_DEF        = 25;
    localparam int unsigned B_W_DEF        = 18;
    localparam int unsigned P_W_DEF        = 48;
    localparam int unsigned FIFO_DEPTH_DEF = 4;
    localparam int unsigned ID_W_DEF       = $clog2(N_REQ_DEF);

    // Edges from request accept to the result being visible at the FIFO head.
    localparam int unsigned LAT = 3;

    typedef struct packed {
        logic [ID_W_DEF-1:0] id;
        logic [P_W_DEF-1:0]  p;
    } rsp_t;

    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/macc_sched_pipe.sv
// Two-stage tagged multiply-add: stage 1 registers a*b, stage 2 adds the carry-in.
// Valid bits shift with the data; synchronous reset drops everything in flight.
module macc_sched_pipe #(
    parameter int unsigned A_W  = 25,
    parameter int unsigned B_W  = 18,
    parameter int unsigned P_W  = 48,
    parameter int unsigned ID_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [A_W-1:0]  in_a,
    input  logic [B_W-1:0]  in_b,
    input  logic            in_cin,
    input  logic [ID_W-1:0] in_id,
    output logic            out_valid,
    output logic [ID_W-1:0] out_id,
    output logic [P_W-1:0]  out_p,
    output logic            active
);

    logic            s1_valid_q, s1_valid_d;
    logic [P_W-1:0]  s1_prod_q,  s1_prod_d;
    logic            s1_cin_q,   s1_cin_d;
    logic [ID_W-1:0] s1_id_q,    s1_id_d;
    logic            s2_valid_q, s2_valid_d;
    logic [P_W-1:0]  s2_p_q,     s2_p_d;
    logic [ID_W-1:0] s2_id_q,    s2_id_d;

    always_comb begin
        s1_valid_d = in_valid;
        s1_prod_d  = P_W'(in_a) * P_W'(in_b);
        s1_cin_d   = in_cin;
        s1_id_d    = in_id;
        s2_valid_d = s1_valid_q;
        s2_p_d     = s1_prod_q + P_W'(s1_cin_q);
        s2_id_d    = s1_id_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_prod_q  <= '0;
            s1_cin_q   <= 1'b0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_p_q     <= '0;
            s2_id_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_prod_q  <= s1_prod_d;
            s1_cin_q   <= s1_cin_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_p_q     <= s2_p_d;
            s2_id_q    <= s2_id_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_id    = s2_id_q;
    assign out_p     = s2_p_q;
    assign active    = s1_valid_q | s2_valid_q;

endmodule

// File: rtl/macc_sched.sv
// Round-robin scheduler sharing one multiply-add pipe among N_REQ requesters.
// Credits reserve a response FIFO slot at issue time so results can never overflow it.
module macc_sched
    import macc_sched_pkg::*;
#(
    parameter int unsigned  N_REQ      = N_REQ_DEF,
    parameter int unsigned  A_W        = A_W_DEF,
    parameter int unsigned  B_W        = B_W_DEF,
    parameter int unsigned  P_W        = P_W_DEF,
    parameter int unsigned  FIFO_DEPTH = FIFO_DEPTH_DEF,
    localparam int unsigned ID_W       = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*A_W-1:0] req_a,
    input  logic [N_REQ*B_W-1:0] req_b,
    input  logic [N_REQ-1:0]     req_cin,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [P_W-1:0]       rsp_p,
    output logic                 busy
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [P_W-1:0]  p;
    } ent_t;

    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0] credits_q, credits_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    ent_t             mem_q [FIFO_DEPTH];
    ent_t             mem_d [FIFO_DEPTH];

    logic             grant_found;
    logic [ID_W-1:0]  grant_idx;
    logic             issue;
    logic [A_W-1:0]   sel_a;
    logic [B_W-1:0]   sel_b;
    logic             sel_cin;

    logic             pipe_valid;
    logic [ID_W-1:0]  pipe_id;
    logic [P_W-1:0]   pipe_p;
    logic             pipe_active;
    logic             fifo_wr;
    logic             fifo_pop;
    logic             fifo_full;

    // Scan from ptr upward with wrap; the first valid requester wins.
    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        issue     = !rst && grant_found && (credits_q != '0);
        req_ready = issue ? (N_REQ'(1) << grant_idx) : '0;
        sel_a     = req_a[grant_idx*A_W +: A_W];
        sel_b     = req_b[grant_idx*B_W +: B_W];
        sel_cin   = req_cin[grant_idx];
        ptr_d     = issue ? ID_W'(wrap_inc(32'(grant_idx), N_REQ)) : ptr_q;
    end

    macc_sched_pipe #(
        .A_W  (A_W),
        .B_W  (B_W),
        .P_W  (P_W),
        .ID_W (ID_W)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (issue),
        .in_a      (sel_a),
        .in_b      (sel_b),
        .in_cin    (sel_cin),
        .in_id     (grant_idx),
        .out_valid (pipe_valid),
        .out_id    (pipe_id),
        .out_p     (pipe_p),
        .active    (pipe_active)
    );

    assign fifo_wr   = pipe_valid;
    assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
    assign rsp_valid = !rst && (count_q != '0);
    assign fifo_pop  = rsp_valid && rsp_ready;
    assign rsp_id    = rsp_valid ? mem_q[rd_ptr_q].id : '0;
    assign rsp_p     = rsp_valid ? mem_q[rd_ptr_q].p  : '0;
    assign busy      = !rst && (pipe_active || (count_q != '0));

    // A write into a full FIFO is legal only alongside a pop; the write slot is the one being freed.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (fifo_wr) begin
            mem_d[wr_ptr_q] = '{id: pipe_id, p: pipe_p};
            wr_ptr_d        = PTR_W'(wrap_inc(32'(wr_ptr_q), FIFO_DEPTH));
        end
        if (fifo_pop) begin
            rd_ptr_d = PTR_W'(wrap_inc(32'(rd_ptr_q), FIFO_DEPTH));
        end
    end

    always_comb begin
        count_d   = count_q;
        credits_d = credits_q;
        case ({fifo_wr, fifo_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        case ({issue, fifo_pop})
            2'b10:   credits_d = credits_q - CNT_W'(1);
            2'b01:   credits_d = credits_q + CNT_W'(1);
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            credits_q <= CNT_W'(FIFO_DEPTH);
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            ptr_q     <= ptr_d;
            credits_q <= credits_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read while count_q covers them.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(fifo_wr && fifo_full && !fifo_pop));
            assert (!(issue && credits_q == '0));
        end
    end

endmodule
